chimera_widemem_bypass_ctrl: RTL and testbench

//  Safe sequencer for the cluster's wide-memory bypass mode. Sits on the cluster wide AXI output ahead of
//  the cluster adapter and owns the adapter's bypass-mode input. On a mode-change request it stops new
//  AW/AR issue, drains outstanding wide bursts, flips the mode, waits a settle time, then reopens traffic,
//  so no wide burst ever straddles a routing change. Handshake level only; AXI payloads bypass this block.

---
 rtl/chimera_widemem_bypass_ctrl_if.sv | 38 +++
 rtl/chimera_widemem_bypass_ctrl.sv | 174 +++++++++++++++++
 tb/tb_chimera_widemem_bypass_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chimera_widemem_bypass_ctrl_if.sv
// ----------------------------------------------------------------------------
// chimera_widemem_bypass_ctrl_if
// Handshake-level view of the cluster wide AXI port as seen by the bypass
// sequencer. The AXI payloads do not pass through this interface.
//   mst_aw/ar_*  : cluster side of the AW/AR channels (valid in, ready out)
//   slv_aw/ar_*  : adapter side of the AW/AR channels (valid out, ready in)
//   b_*, r_*     : observed response handshakes (never gated)
// Modports:
//   slave  - sequencer view
//   master - environment view (drives cluster valids, adapter readies, B/R)
// ----------------------------------------------------------------------------
interface chimera_widemem_bypass_ctrl_if;
    logic mst_aw_valid_i;
    logic mst_aw_ready_o;
    logic slv_aw_valid_o;
    logic slv_aw_ready_i;
    logic mst_ar_valid_i;
    logic mst_ar_ready_o;
    logic slv_ar_valid_o;
    logic slv_ar_ready_i;
    logic b_valid_i;
    logic b_ready_i;
    logic r_valid_i;
    logic r_ready_i;
    logic r_last_i;

    modport slave (
        input  mst_aw_valid_i, slv_aw_ready_i, mst_ar_valid_i, slv_ar_ready_i,
        input  b_valid_i, b_ready_i, r_valid_i, r_ready_i, r_last_i,
        output mst_aw_ready_o, slv_aw_valid_o, mst_ar_ready_o, slv_ar_valid_o
    );

    modport master (
        output mst_aw_valid_i, slv_aw_ready_i, mst_ar_valid_i, slv_ar_ready_i,
        output b_valid_i, b_ready_i, r_valid_i, r_ready_i, r_last_i,
        input  mst_aw_ready_o, slv_aw_valid_o, mst_ar_ready_o, slv_ar_valid_o
    );
endinterface

// File: rtl/chimera_widemem_bypass_ctrl.sv
// ----------------------------------------------------------------------------
// chimera_widemem_bypass_ctrl
// Safe sequencer for the wide-memory bypass mode. On a mode-change request it
// stops new AW/AR issue, waits for all outstanding wide bursts to complete,
// flips bypass_o, holds traffic off for a settle time and then reopens.
// Ports:
//   soc_clk_i    - clock
//   rst_ni       - asynchronous active-low reset
//   bypass_req_i - requested bypass mode (level)
//   bypass_o     - applied bypass mode (registered)
//   busy_o       - high while a mode change is in progress
//   err_o        - sticky: B or R-last seen with its outstanding count at 0
//   io_bus       - AW/AR gating and B/R observation (slave modport)
// ----------------------------------------------------------------------------
module chimera_widemem_bypass_ctrl #(
    parameter int unsigned MaxOutstanding = 16,
    parameter int unsigned SettleCycles   = 2,
    parameter bit          ResetBypass    = 1'b0
) (
    input  logic                                soc_clk_i,
    input  logic                                rst_ni,
    input  logic                                bypass_req_i,
    output logic                                bypass_o,
    output logic                                busy_o,
    output logic                                err_o,
    chimera_widemem_bypass_ctrl_if.slave        io_bus
);

    localparam int unsigned CW = $clog2(MaxOutstanding + 1);
    localparam int unsigned SW = (SettleCycles > 0) ? $clog2(SettleCycles + 1) : 1;
    localparam logic [CW-1:0] MaxCnt     = CW'(MaxOutstanding);
    localparam logic [SW-1:0] SettleLoad = SW'(SettleCycles);

    typedef enum logic [1:0] {
        StIdle,
        StDrain,
        StSwitch,
        StSettle
    } state_e;

    state_e         r_state;
    state_e         w_state_next;
    logic [CW-1:0]  r_wr_cnt;
    logic [CW-1:0]  r_rd_cnt;
    logic [CW-1:0]  w_wr_cnt_next;
    logic [CW-1:0]  r_rd_cnt_next_unused;
    logic [CW-1:0]  w_rd_cnt_next;
    logic [SW-1:0]  r_settle_cnt;
    logic           r_aw_hold;
    logic           r_ar_hold;
    logic           r_target;
    logic           r_bypass;
    logic           r_err;

    logic           w_aw_hs;
    logic           w_ar_hs;
    logic           w_b_hs;
    logic           w_r_hs;
    logic           w_block_aw;
    logic           w_block_ar;
    logic           w_drained;

    assign r_rd_cnt_next_unused = '0;

    // Handshakes are observed on the adapter side so only beats that really
    // left the block are counted.
    assign w_aw_hs = io_bus.slv_aw_valid_o & io_bus.slv_aw_ready_i;
    assign w_ar_hs = io_bus.slv_ar_valid_o & io_bus.slv_ar_ready_i;
    assign w_b_hs  = io_bus.b_valid_i & io_bus.b_ready_i;
    assign w_r_hs  = io_bus.r_valid_i & io_bus.r_ready_i & io_bus.r_last_i;

    assign w_drained = (r_wr_cnt == '0) & (r_rd_cnt == '0) & ~r_aw_hold & ~r_ar_hold;

    // Outstanding counters: simultaneous inc/dec cancels, decrement at zero
    // is clamped (and flagged through r_err).
    always_comb begin
        w_wr_cnt_next = r_wr_cnt;
        if (w_aw_hs && !w_b_hs && r_wr_cnt != MaxCnt) begin
            w_wr_cnt_next = r_wr_cnt + CW'(1);
        end else if (!w_aw_hs && w_b_hs && r_wr_cnt != '0) begin
            w_wr_cnt_next = r_wr_cnt - CW'(1);
        end
    end

    always_comb begin
        w_rd_cnt_next = r_rd_cnt;
        if (w_ar_hs && !w_r_hs && r_rd_cnt != MaxCnt) begin
            w_rd_cnt_next = r_rd_cnt + CW'(1);
        end else if (!w_ar_hs && w_r_hs && r_rd_cnt != '0) begin
            w_rd_cnt_next = r_rd_cnt - CW'(1);
        end
    end

    // FSM state register
    always_ff @(posedge soc_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (bypass_req_i != r_bypass) w_state_next = StDrain;
            end
            StDrain: begin
                // Request withdrawn before the switch: abort without touching the mode.
                if (bypass_req_i == r_bypass) begin
                    w_state_next = StIdle;
                end else if (w_drained) begin
                    w_state_next = StSwitch;
                end
            end
            StSwitch: begin
                w_state_next = (SettleCycles == 0) ? StIdle : StSettle;
            end
            StSettle: begin
                if (r_settle_cnt <= SW'(1)) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // FSM outputs and gating
    always_comb begin
        busy_o     = (r_state != StIdle);
        // A beat already offered to the adapter is never withdrawn.
        w_block_aw = (busy_o | (r_wr_cnt == MaxCnt)) & ~r_aw_hold;
        w_block_ar = (busy_o | (r_rd_cnt == MaxCnt)) & ~r_ar_hold;
        io_bus.slv_aw_valid_o = io_bus.mst_aw_valid_i & ~w_block_aw;
        io_bus.mst_aw_ready_o = io_bus.slv_aw_ready_i & ~w_block_aw;
        io_bus.slv_ar_valid_o = io_bus.mst_ar_valid_i & ~w_block_ar;
        io_bus.mst_ar_ready_o = io_bus.slv_ar_ready_i & ~w_block_ar;
    end

    // Datapath registers
    always_ff @(posedge soc_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_cnt     <= '0;
            r_rd_cnt     <= '0;
            r_settle_cnt <= '0;
            r_aw_hold    <= 1'b0;
            r_ar_hold    <= 1'b0;
            r_target     <= ResetBypass;
            r_bypass     <= ResetBypass;
            r_err        <= 1'b0;
        end else begin
            r_wr_cnt  <= w_wr_cnt_next;
            r_rd_cnt  <= w_rd_cnt_next;
            r_aw_hold <= io_bus.slv_aw_valid_o & ~io_bus.slv_aw_ready_i;
            r_ar_hold <= io_bus.slv_ar_valid_o & ~io_bus.slv_ar_ready_i;
            if ((w_b_hs && r_wr_cnt == '0) || (w_r_hs && r_rd_cnt == '0)) begin
                r_err <= 1'b1;
            end
            if (r_state == StIdle && bypass_req_i != r_bypass) begin
                r_target <= bypass_req_i;
            end
            if (r_state == StSwitch) begin
                r_bypass     <= r_target;
                r_settle_cnt <= SettleLoad;
            end else if (r_state == StSettle && r_settle_cnt != '0) begin
                r_settle_cnt <= r_settle_cnt - SW'(1);
            end
        end
    end

    assign bypass_o = r_bypass;
    assign err_o    = r_err;

endmodule

// File: tb/tb_chimera_widemem_bypass_ctrl.sv
// ----------------------------------------------------------------------------
// tb_chimera_widemem_bypass_ctrl
// Directed bench for the bypass sequencer. Stimulus pushes cycle-tagged
// expectations into a scoreboard queue; a monitor on the falling edge pops
// and compares every entry due in the current cycle.
// ----------------------------------------------------------------------------
module tb_chimera_widemem_bypass_ctrl;

  typedef enum int {SBypass, SBusy, SErr, SAwV, SAwR, SArV, SArR} sig_e;

  typedef struct {
    int    cyc;
    sig_e  sig;
    logic  val;
    string name;
  } exp_t;

  logic clk;
  logic rst_ni;
  logic bypass_req;
  logic bypass;
  logic busy;
  logic err;

  int   cyc;
  int   checks;
  int   errors;
  bit   flush;
  exp_t sb_q[$];
  exp_t keep_q[$];
  logic act;

  chimera_widemem_bypass_ctrl_if bus ();

  chimera_widemem_bypass_ctrl #(
    .MaxOutstanding (16),
    .SettleCycles   (2),
    .ResetBypass    (1'b0)
  ) u_dut (
    .soc_clk_i    (clk),
    .rst_ni       (rst_ni),
    .bypass_req_i (bypass_req),
    .bypass_o     (bypass),
    .busy_o       (busy),
    .err_o        (err),
    .io_bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic sig_val(input sig_e s);
    case (s)
      SBypass: return bypass;
      SBusy:   return busy;
      SErr:    return err;
      SAwV:    return bus.slv_aw_valid_o;
      SAwR:    return bus.mst_aw_ready_o;
      SArV:    return bus.slv_ar_valid_o;
      default: return bus.mst_ar_ready_o;
    endcase
  endfunction

  // Monitor: compare everything due now; anything overdue or left at flush fails.
  initial begin
    checks = 0;
    errors = 0;
  end
  always @(negedge clk) begin
    keep_q = {};
    foreach (sb_q[i]) begin
      if (sb_q[i].cyc <= cyc || flush) begin
        act = sig_val(sb_q[i].sig);
        checks++;
        if (sb_q[i].cyc != cyc) begin
          errors++;
          $display("FAIL %s not checked on time: cycle %0d (due %0d)",
                   sb_q[i].name, cyc, sb_q[i].cyc);
        end else if (act !== sb_q[i].val) begin
          errors++;
          $display("FAIL %s cycle %0d: got %b, expected %b",
                   sb_q[i].name, cyc, act, sb_q[i].val);
        end
      end else begin
        keep_q.push_back(sb_q[i]);
      end
    end
    sb_q = keep_q;
  end

  task automatic chk(input int dt, input sig_e s, input logic v, input string n);
    exp_t e;
    e.cyc  = cyc + dt;
    e.sig  = s;
    e.val  = v;
    e.name = n;
    sb_q.push_back(e);
  endtask

  task automatic chk_now(input sig_e s, input logic v, input string n);
    logic a;
    a = sig_val(s);
    checks++;
    if (a !== v) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b, expected %b", n, cyc, a, v);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_b();
    bus.b_valid_i = 1'b1;
    bus.b_ready_i = 1'b1;
    step();
    bus.b_valid_i = 1'b0;
    bus.b_ready_i = 1'b0;
  endtask

  task automatic pulse_r(input logic last);
    bus.r_valid_i = 1'b1;
    bus.r_ready_i = 1'b1;
    bus.r_last_i  = last;
    step();
    bus.r_valid_i = 1'b0;
    bus.r_ready_i = 1'b0;
    bus.r_last_i  = 1'b0;
  endtask

  task automatic drv(input logic [3:0] p);
    bus.mst_aw_valid_i = p[3];
    bus.slv_aw_ready_i = p[2];
    bus.mst_ar_valid_i = p[1];
    bus.slv_ar_ready_i = p[0];
  endtask

  logic [3:0] pats [10];

  initial begin
    flush      = 1'b0;
    rst_ni     = 1'b0;
    bypass_req = 1'b0;
    drv(4'b0000);
    bus.b_valid_i = 1'b0;
    bus.b_ready_i = 1'b0;
    bus.r_valid_i = 1'b0;
    bus.r_ready_i = 1'b0;
    bus.r_last_i  = 1'b0;
    pats = '{4'b0000, 4'b1000, 4'b0100, 4'b1100, 4'b0010,
             4'b0001, 4'b0011, 4'b1111, 4'b1010, 4'b0101};
    step(3);
    rst_ni = 1'b1;

    // Reset state
    chk_now(SBypass, 1'b0, "rst_bypass");
    chk_now(SBusy,   1'b0, "rst_busy");
    chk_now(SErr,    1'b0, "rst_err");
    step();

    // 1: idle pass-through (2 writes and 2 reads get counted)
    foreach (pats[i]) begin
      drv(pats[i]);
      chk(0, SAwV,  pats[i][3], "t1_aw_valid");
      chk(0, SAwR,  pats[i][2], "t1_aw_ready");
      chk(0, SArV,  pats[i][1], "t1_ar_valid");
      chk(0, SArR,  pats[i][0], "t1_ar_ready");
      chk(0, SBusy, 1'b0,       "t1_busy");
      step();
    end
    drv(4'b0000);
    pulse_b();
    pulse_b();
    pulse_r(1'b0);
    pulse_r(1'b1);
    pulse_r(1'b1);
    chk(0, SErr, 1'b0, "t1_no_err");
    step();

    // 2: switch with an empty port, 0 -> 1
    bypass_req = 1'b1;
    chk(0, SBusy,   1'b0, "t2_busy_n");
    chk(0, SBypass, 1'b0, "t2_bypass_n");
    chk(1, SBusy,   1'b1, "t2_busy_n1");
    chk(2, SBypass, 1'b0, "t2_bypass_n2");
    chk(2, SBusy,   1'b1, "t2_busy_n2");
    chk(3, SBypass, 1'b1, "t2_bypass_n3");
    chk(4, SBusy,   1'b1, "t2_busy_n4");
    chk(5, SBusy,   1'b0, "t2_busy_n5");
    chk(5, SBypass, 1'b1, "t2_bypass_n5");
    step();
    drv(4'b1001);
    for (int d = 0; d < 4; d++) begin
      chk(d, SAwV, 1'b0, "t2_aw_blocked");
      chk(d, SArR, 1'b0, "t2_ar_blocked");
    end
    chk(4, SAwV, 1'b1, "t2_aw_reopen");
    chk(4, SArR, 1'b1, "t2_ar_reopen");
    step(5);
    drv(4'b0000);
    step(2);

    // 3: drain 3 writes + 2 reads, then switch back to 0
    drv(4'b1111);
    step(2);
    drv(4'b1100);
    step();
    drv(4'b0000);
    bypass_req = 1'b0;
    step();
    drv(4'b1001);
    chk(0, SBusy,   1'b1, "t3_busy");
    chk(0, SBypass, 1'b1, "t3_bypass_hold0");
    chk(0, SAwV,    1'b0, "t3_aw_blocked");
    chk(0, SArR,    1'b0, "t3_ar_blocked");
    pulse_b();
    chk(0, SBypass, 1'b1, "t3_bypass_hold1");
    chk(0, SArR,    1'b0, "t3_ar_blocked1");
    pulse_b();
    pulse_r(1'b0);
    chk(0, SBypass, 1'b1, "t3_bypass_hold2");
    pulse_r(1'b1);
    pulse_r(1'b1);
    chk(0, SBypass, 1'b1, "t3_bypass_hold3");
    chk(0, SBusy,   1'b1, "t3_busy_wait_b");
    chk(1, SBypass, 1'b1, "t3_bypass_k1");
    chk(2, SBypass, 1'b1, "t3_bypass_k2");
    chk(3, SBypass, 1'b0, "t3_bypass_k3");
    chk(3, SBusy,   1'b1, "t3_busy_k3");
    chk(4, SBusy,   1'b1, "t3_busy_k4");
    chk(4, SAwV,    1'b0, "t3_aw_settle");
    chk(5, SBusy,   1'b0, "t3_busy_k5");
    chk(5, SAwV,    1'b1, "t3_aw_reopen");
    chk(5, SArR,    1'b1, "t3_ar_reopen");
    pulse_b();
    step(5);
    drv(4'b0000);
    step(2);

    // 4: held AW beat during a switch request
    drv(4'b1000);
    bypass_req = 1'b1;
    chk(0, SAwV, 1'b1, "t4_aw_offer");
    for (int d = 1; d < 5; d++) begin
      chk(d, SAwV,  1'b1, "t4_aw_held");
      chk(d, SAwR,  1'b0, "t4_aw_rdy_low");
      chk(d, SBusy, 1'b1, "t4_busy");
    end
    step(5);
    drv(4'b1100);
    chk(0, SAwR, 1'b1, "t4_aw_complete");
    chk(0, SAwV, 1'b1, "t4_aw_valid_cmpl");
    chk(1, SAwV, 1'b0, "t4_aw_blocked_after");
    chk(1, SAwR, 1'b0, "t4_aw_rdy_after");
    step(2);
    drv(4'b0000);
    chk(0, SBypass, 1'b0, "t4_wait_b0");
    chk(0, SBusy,   1'b1, "t4_busy_wait");
    step();
    chk(0, SBypass, 1'b0, "t4_wait_b1");
    chk(2, SBypass, 1'b0, "t4_bypass_k2");
    chk(3, SBypass, 1'b1, "t4_bypass_k3");
    chk(4, SBusy,   1'b1, "t4_busy_k4");
    chk(5, SBusy,   1'b0, "t4_busy_k5");
    pulse_b();
    step(6);

    // 5: saturation at 16 writes, then an aborted request
    drv(4'b1100);
    for (int i = 0; i < 16; i++) begin
      chk(0, SAwR, 1'b1, "t5_aw_accept");
      step();
    end
    chk(0, SAwV, 1'b0, "t5_sat_valid");
    chk(0, SAwR, 1'b0, "t5_sat_ready");
    step();
    chk(0, SAwV, 1'b0, "t5_sat_valid1");
    pulse_b();
    chk(0, SAwV, 1'b1, "t5_unsat_valid");
    chk(0, SAwR, 1'b1, "t5_unsat_ready");
    step();
    chk(0, SAwV, 1'b0, "t5_resat_valid");
    drv(4'b0000);
    step();
    bypass_req = 1'b0;
    chk(1, SBusy,   1'b1, "t5_abort_drain");
    chk(1, SBypass, 1'b1, "t5_abort_byp1");
    step();
    bypass_req = 1'b1;
    chk(1, SBusy, 1'b0, "t5_abort_idle");
    for (int d = 1; d < 5; d++) chk(d, SBypass, 1'b1, "t5_abort_bypass");
    step(5);
    for (int i = 0; i < 16; i++) pulse_b();
    chk(0, SErr, 1'b0, "t5_err_clear");
    step();

    // 6: error is sticky; reset in SETTLE restores reset values
    chk(0, SErr, 1'b0, "t6_err_before");
    chk(1, SErr, 1'b1, "t6_err_set");
    pulse_b();
    step(3);
    chk(0, SErr, 1'b1, "t6_err_sticky");
    bypass_req = 1'b0;
    step(7);
    chk(0, SBypass, 1'b0, "t6_bypass_back0");
    bypass_req = 1'b1;
    chk(3, SBypass, 1'b1, "t6_bypass_settle");
    chk(3, SBusy,   1'b1, "t6_busy_settle");
    step(4);
    rst_ni     = 1'b0;
    bypass_req = 1'b0;
    chk(0, SBypass, 1'b0, "t6_rst_bypass");
    chk(0, SBusy,   1'b0, "t6_rst_busy");
    chk(0, SErr,    1'b0, "t6_rst_err");
    step(2);
    rst_ni = 1'b1;
    chk(0, SBusy,   1'b0, "t6_post_busy");
    chk(2, SBusy,   1'b0, "t6_post_busy2");
    chk(2, SBypass, 1'b0, "t6_post_bypass2");
    step(4);

    flush = 1'b1;
    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
